// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: bubble encoding, PC step and the IF/ID payload.
package fetch_pkg;

   // sll $0,$0,0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] PC_INCR   = 32'd4;

   // IF/ID pipeline payload, also consumed by the decode stage.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc_plus4;
      logic        valid;
      logic        fault;
   } if_id_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register. Priority: reset > flush > stall (hold) > load.
module if_id_register
   import fetch_pkg::*;
#(
   parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   stall,
   input  logic   flush,
   input  if_id_t if_id_d,
   output if_id_t if_id_q
);

   if_id_t bubble;

   assign bubble = '{instr: NOP_WORD, pc_plus4: 32'd0, valid: 1'b0, fault: 1'b0};

   // Bubble on reset or flush, hold on stall, otherwise take the new fetch.
   always_ff @(posedge clk) begin
      if (reset) begin
         if_id_q <= bubble;
      end else if (flush) begin
         if_id_q <= bubble;
      end else if (!stall) begin
         if_id_q <= if_id_d;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch stage: owns the PC, picks the next PC, range-checks the fetch and
// counts delivered instructions. IF/ID state lives in if_id_register.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_DEPTH = 256,
   parameter logic [31:0] NOP_WORD   = fetch_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [25:0] jump_index,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc_plus4,
   output logic        if_id_valid,
   output logic        if_id_fault,
   output logic [31:0] fetch_count
);

   import fetch_pkg::*;

   // 33 bits so a memory reaching the top of the address space still compares correctly.
   localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_DEPTH) * 33'd4;

   logic [31:0] pc_q, pc_d, pc_plus4, redirect_pc;
   logic [31:0] fetch_count_q;
   logic        redirect, in_range, capture;
   if_id_t      if_id_d, if_id_q;

   assign pc_plus4 = pc_q + PC_INCR;
   assign redirect = branch_taken | jump;
   assign in_range = {1'b0, pc_q} < IMEM_LIMIT;
   assign capture  = ~redirect & ~stall & in_range;

   // Next PC: branch beats jump (the jump sits in the flushed slot), redirect beats stall.
   always_comb begin
      redirect_pc = {pc_q[31:28], jump_index, 2'b00};
      if (branch_taken) begin
         redirect_pc = {branch_target[31:2], 2'b00};
      end
      pc_d = pc_plus4;
      if (redirect) begin
         pc_d = redirect_pc;
      end else if (stall) begin
         pc_d = pc_q;
      end
   end

   // Payload offered to IF/ID; out-of-range fetches become a faulted bubble.
   always_comb begin
      if_id_d.instr    = in_range ? imem_instr : NOP_WORD;
      if_id_d.pc_plus4 = pc_plus4;
      if_id_d.valid    = in_range;
      if_id_d.fault    = ~in_range;
   end

   // PC and delivered-instruction counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         fetch_count_q <= 32'd0;
      end else begin
         pc_q <= pc_d;
         if (capture) begin
            fetch_count_q <= fetch_count_q + 32'd1;
         end
      end
   end

   if_id_register #(
      .NOP_WORD (NOP_WORD)
   ) u_if_id (
      .clk     (clk),
      .reset   (reset),
      .stall   (stall),
      .flush   (redirect),
      .if_id_d (if_id_d),
      .if_id_q (if_id_q)
   );

   assign imem_addr      = pc_q;
   assign if_id_instr    = if_id_q.instr;
   assign if_id_pc_plus4 = if_id_q.pc_plus4;
   assign if_id_valid    = if_id_q.valid;
   assign if_id_fault    = if_id_q.fault;
   assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by random traffic,
// all checked against a behavioural model of the fetch stage.
module tb_fetch_sequencer;

   localparam int unsigned DEPTH = 256;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [25:0] jump_index;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc_plus4;
   logic        if_id_valid;
   logic        if_id_fault;
   logic [31:0] fetch_count;

   logic [31:0] mem [DEPTH];

   // Model state
   logic [31:0] m_pc, m_instr, m_pc4, m_count;
   logic        m_valid, m_fault;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // Combinational instruction memory; garbage outside the populated range.
   always_comb begin
      imem_instr = 32'hDEAD_BEEF;
      if (imem_addr < DEPTH * 4) imem_instr = mem[imem_addr[9:2]];
   end

   fetch_sequencer #(
      .RESET_PC   (RST_PC),
      .IMEM_DEPTH (DEPTH),
      .NOP_WORD   (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .stall          (stall),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .jump           (jump),
      .jump_index     (jump_index),
      .if_id_instr    (if_id_instr),
      .if_id_pc_plus4 (if_id_pc_plus4),
      .if_id_valid    (if_id_valid),
      .if_id_fault    (if_id_fault),
      .fetch_count    (fetch_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      check("imem_addr", imem_addr, m_pc);
      check("if_id_instr", if_id_instr, m_instr);
      check("if_id_pc_plus4", if_id_pc_plus4, m_pc4);
      check("if_id_valid", 32'(if_id_valid), 32'(m_valid));
      check("if_id_fault", 32'(if_id_fault), 32'(m_fault));
      check("fetch_count", fetch_count, m_count);
   endtask

   // One clock: drive inputs, advance the model from the spec rules, then compare.
   task automatic cycle(input logic rst, input logic st, input logic br,
                        input logic [31:0] bt, input logic j, input logic [25:0] ji);
      logic [31:0] npc;
      reset = rst; stall = st; branch_taken = br; branch_target = bt;
      jump = j; jump_index = ji;
      if (rst)      npc = RST_PC;
      else if (br)  npc = bt & 32'hFFFF_FFFC;
      else if (j)   npc = (m_pc & 32'hF000_0000) | (32'(ji) * 4);
      else if (st)  npc = m_pc;
      else          npc = m_pc + 32'd4;
      if (rst) begin
         m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_fault = 1'b0; m_count = 32'h0;
      end else if (br || j) begin
         m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_fault = 1'b0;
      end else if (!st) begin
         m_pc4 = m_pc + 32'd4;
         if (m_pc < DEPTH * 4) begin
            m_instr = mem[m_pc / 4]; m_valid = 1'b1; m_fault = 1'b0; m_count = m_count + 1;
         end else begin
            m_instr = 32'h0; m_valid = 1'b0; m_fault = 1'b1;
         end
      end
      m_pc = npc;
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
   endtask

   task automatic go(input logic [31:0] target);
      cycle(1'b0, 1'b0, 1'b1, target, 1'b0, 26'h0);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      for (int i = 0; i < 4; i++) mem[i] = 32'h2008_0001 + 32'(i);
      m_pc = 32'hx; m_instr = 32'hx; m_pc4 = 32'hx; m_valid = 1'bx; m_fault = 1'bx;
      m_count = 32'hx;
      #1;

      // Reset for two cycles
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
      check("reset_pc", imem_addr, 32'h0);
      check("reset_valid", 32'(if_id_valid), 32'h0);

      // Free run: first slot holds row 0
      run(1);
      check("first_instr", if_id_instr, 32'h2008_0001);
      check("first_pc4", if_id_pc_plus4, 32'h4);
      run(1);
      // Stall at pc 8 for three cycles, then release
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
      check("stall_pc", imem_addr, 32'h8);
      run(2);
      check("count_after4", fetch_count, 32'd4);

      // Branch while stalled at pc 0x10
      cycle(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 26'h0);
      check("br_pc", imem_addr, 32'h40);
      check("br_flush_valid", 32'(if_id_valid), 32'h0);
      run(1);
      check("br_capture", if_id_instr, mem[16]);
      check("br_pc4", if_id_pc_plus4, 32'h44);

      // Branch and jump together: branch wins
      cycle(1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 26'h10);
      check("br_beats_jump", imem_addr, 32'h80);
      // Jump alone from the upper region
      go(32'h1000_0008);
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'h10);
      check("jump_pc", imem_addr, 32'h1000_0040);

      // Misaligned branch target, then end of memory
      go(32'h0000_03FB);
      check("align_pc", imem_addr, 32'h3F8);
      run(3);
      check("oob_fault", 32'(if_id_fault), 32'h1);
      check("oob_pc4", if_id_pc_plus4, 32'h404);

      // PC wrap at the top of the address space
      go(32'hFFFF_FFFC);
      run(1);
      check("wrap_pc", imem_addr, 32'h0);

      // Mid-run reset at pc 0x24
      go(32'h10);
      run(5);
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
      check("midreset_count", fetch_count, 32'h0);
      run(2);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         logic        r, s, b, jj;
         logic [31:0] t;
         r  = ($urandom_range(0, 63) == 0);
         s  = ($urandom_range(0, 3) == 0);
         b  = ($urandom_range(0, 9) == 0);
         jj = ($urandom_range(0, 9) == 0);
         t  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 1100));
         cycle(r, s, b, t, jj, 26'($urandom_range(0, 300)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Fetch-stage sequencer for the 5-stage MIPS pipeline. It owns the program counter and drives the word address into the combinational instruction memory. It captures the returned instruction into the IF/ID pipeline register. It applies hazard-unit stalls and branch/jump redirects with the corresponding flush, and flags fetches outside the populated memory range.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
IMEM_DEPTH, 256, number of 32-bit words in instruction memory; fetch addresses at or above IMEM_DEPTH*4 are out of range
NOP_WORD, 32'h0000_0000, bubble inserted into IF/ID (sll $0,$0,0)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_addr  output  32  byte address to instruction memory (= pc_q)
imem_instr  input  32  instruction word returned combinationally for imem_addr
stall  input  1  hazard unit: hold PC and IF/ID
branch_taken  input  1  EX-resolved branch taken
branch_target  input  32  byte target of taken branch
jump  input  1  ID-decoded j/jal
jump_index  input  26  instr_index field of jump
if_id_instr  output  32  IF/ID instruction
if_id_pc_plus4  output  32  IF/ID PC+4
if_id_valid  output  1  IF/ID holds a real instruction
if_id_fault  output  1  IF/ID slot came from an out-of-range fetch
fetch_count  output  32  count of valid instructions delivered into IF/ID

Behaviour:
- Reset (sync, active-high; applies whenever sampled high, including mid-operation):
  - pc_q<=RESET_PC; if_id_instr<=NOP_WORD; if_id_pc_plus4<=0; if_id_valid<=0; if_id_fault<=0; fetch_count<=0.
  - Instruction memory initialises during reset cycles, so no fetch result is captured while reset is high.
- imem_addr = pc_q, combinational. Fetch latency: the instruction at pc_q appears on if_id_* one edge later.
- pc_plus4 = pc_q + 32'd4, modulo 2^32 (wraps 0xFFFF_FFFC -> 0x0000_0000).
- Redirect target:
  - branch_taken: {branch_target[31:2],2'b00}.
  - jump (without branch_taken): {pc_q[31:28], jump_index, 2'b00}. pc_q is the slot after the jump, i.e. the jump's PC+4.
  - Misaligned branch targets are force-aligned.
- Next-PC priority, per edge: reset > branch_taken > jump > stall (hold pc_q) > pc_plus4.
  - A redirect overrides stall: the stalled ID instruction is younger than the branch and is discarded.
- IF/ID update, same priority:
  - Redirect (branch_taken or jump): flush. if_id_instr<=NOP_WORD, if_id_valid<=0, if_id_fault<=0, if_id_pc_plus4<=0.
  - Stall, no redirect: all if_id_* hold.
  - Normal, in range (pc_q < IMEM_DEPTH*4): if_id_instr<=imem_instr, if_id_pc_plus4<=pc_plus4, if_id_valid<=1, if_id_fault<=0.
  - Normal, out of range: if_id_instr<=NOP_WORD, if_id_pc_plus4<=pc_plus4, if_id_valid<=0, if_id_fault<=1. The PC keeps advancing; no sticky state.
- fetch_count increments by 1 on each edge where if_id_valid is loaded with 1 (normal in-range capture). Wraps at 2^32. Holds on stall, flush and fault.
- Simultaneous branch_taken and jump: the branch wins and the jump is discarded (it lives in the flushed ID slot).
- No internal FSM beyond the PC and IF/ID registers. The out-of-range check is a compare against the constant IMEM_DEPTH*4.

Decomposition:
- Shared package (fetch_pkg): NOP_WORD, the PC increment constant, and a packed if_id_t struct {instr, pc_plus4, valid, fault} reused by the decode stage.
- One natural sub-module: if_id_register. It holds the if_id_t with stall/flush/reset priority. fetch_sequencer keeps the PC, next-PC mux, range check and counter.

Test Plan:
- Reset 2 cycles, then free-run with imem rows 0..3 = 0x20080001.. -> imem_addr 0,4,8,12 on consecutive cycles. if_id_instr = row0 one edge after reset release with pc_plus4=4, valid=1. fetch_count=4 after 4 captures.
- stall high 3 cycles at pc_q=8 -> imem_addr stays 8, if_id_* unchanged, fetch_count unchanged. Release -> capture at 8 then 12.
- branch_taken with target 0x40 while stall=1 at pc_q=0x10 -> next edge pc_q=0x40, if_id_valid=0, if_id_instr=0. The following edge captures word 16 with pc_plus4=0x44.
- jump with jump_index=0x000_0010 and branch_taken simultaneously with target 0x80 -> pc_q=0x80. Jump alone at pc_q=0x1000_0008 -> pc_q=0x1000_0040.
- Run PC to 0x3FC then 0x400 with IMEM_DEPTH=256 -> slot from 0x3FC valid=1, fault=0. Slot from 0x400 valid=0, fault=1, instr=0. fetch_count stops incrementing.
- Assert reset for one cycle mid-run at pc_q=0x24 -> next edge pc_q=RESET_PC, if_id_valid=0, fetch_count=0. Normal fetch resumes from 0.
